// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit arbiter: FSM encoding and
// elaboration-time sizing helpers.
package uart_pkg;

  typedef enum logic {
    IDLE,
    STREAM
  } state_t;

  // Ceiling log2, never less than 1 so derived vector widths stay legal.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned bits;
    bits = 0;
    for (int unsigned v = value - 1; v != 0; v = v >> 1) begin
      bits++;
    end
    return (bits == 0) ? 1 : bits;
  endfunction

  // Clocks per UART byte (10 bit times) plus slack for the UART's byte load.
  function automatic int unsigned byte_cycles(input int unsigned clk_hz,
                                              input int unsigned baud);
    return 10 * (clk_hz / baud) + 2;
  endfunction

endpackage

// File: rtl/uart_tx_credit.sv
// Credit counter modelling UART tx FIFO occupancy: a free-running byte timer
// returns one credit per byte time, each accepted byte consumes one.
module uart_tx_credit
  import uart_pkg::*;
#(
  parameter int unsigned BYTE_CYCLES = byte_cycles(27000000, 115200),
  parameter int unsigned FIFO_DEPTH  = 64
) (
  input  logic                             clock,
  input  logic                             reset_n,
  input  logic                             consume,
  output logic                             credit_avail,
  output logic [clog2(FIFO_DEPTH + 1)-1:0] credits
);

  localparam int unsigned TW = clog2(BYTE_CYCLES);
  localparam int unsigned CW = clog2(FIFO_DEPTH + 1);

  logic [TW-1:0] timer;
  logic          wrap;

  assign wrap         = (timer == TW'(BYTE_CYCLES - 1));
  assign credit_avail = (credits != '0);

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      timer   <= '0;
      credits <= '0;
    end else begin
      timer <= wrap ? '0 : timer + 1'b1;
      unique case ({wrap, consume})
        2'b10: if (credits != CW'(FIFO_DEPTH)) credits <= credits + 1'b1;
        2'b01: if (credit_avail) credits <= credits - 1'b1;
        default: credits <= credits;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin, message-granular arbiter sharing the UART tx FIFO write port
// between NUM_REQ byte streams, paced by a credit model of FIFO occupancy.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int unsigned NUM_REQ         = 4,
  parameter int unsigned CLOCK_FREQUENCY = 27000000,
  parameter int unsigned BAUD_RATE       = 115200,
  parameter int unsigned FIFO_DEPTH      = 64,
  parameter int unsigned MAX_MSG_LEN     = 64
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [8*NUM_REQ-1:0]       req_data,
  input  logic [NUM_REQ-1:0]         req_last,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic [7:0]                 tx_fifo_data_in,
  output logic                       tx_fifo_write_en,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       busy
);

  localparam int unsigned GW          = $clog2(NUM_REQ);
  localparam int unsigned BW          = clog2(MAX_MSG_LEN);
  localparam int unsigned CW          = clog2(FIFO_DEPTH + 1);
  localparam int unsigned BYTE_CYCLES = byte_cycles(CLOCK_FREQUENCY, BAUD_RATE);

  state_t        state;
  logic [GW-1:0] last_grant;
  logic [GW-1:0] pick;
  logic          pick_valid;
  logic [BW-1:0] byte_cnt;
  logic [CW-1:0] credits;
  logic          credit_avail;
  logic          accept;
  logic [7:0]    req_byte [NUM_REQ];

  uart_tx_credit #(
    .BYTE_CYCLES(BYTE_CYCLES),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_credit (
    .clock       (clock),
    .reset_n     (reset_n),
    .consume     (accept),
    .credit_avail(credit_avail),
    .credits     (credits)
  );

  always_comb begin
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      req_byte[i] = req_data[8*i +: 8];
    end
  end

  // First valid requester after the last granted one, wrapping around.
  always_comb begin
    int unsigned   idx;
    logic [GW-1:0] cand;
    idx        = 0;
    cand       = '0;
    pick       = last_grant;
    pick_valid = 1'b0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      idx  = (32'(last_grant) + k) % NUM_REQ;
      cand = GW'(idx);
      if (!pick_valid && req_valid[cand]) begin
        pick       = cand;
        pick_valid = 1'b1;
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (state == STREAM && credit_avail) req_ready[grant_id] = 1'b1;
  end

  assign accept = req_valid[grant_id] & req_ready[grant_id];

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state            <= IDLE;
      grant_id         <= '0;
      last_grant       <= GW'(NUM_REQ - 1);
      byte_cnt         <= '0;
      busy             <= 1'b0;
      tx_fifo_write_en <= 1'b0;
      tx_fifo_data_in  <= '0;
    end else begin
      tx_fifo_write_en <= 1'b0;
      unique case (state)
        IDLE: begin
          if (pick_valid && credits != '0) begin
            grant_id <= pick;
            byte_cnt <= '0;
            busy     <= 1'b1;
            state    <= STREAM;
          end
        end
        STREAM: begin
          if (accept) begin
            tx_fifo_data_in  <= req_byte[grant_id];
            tx_fifo_write_en <= 1'b1;
            byte_cnt         <= byte_cnt + 1'b1;
            // Only the last flag or the length guard ends a grant; valid gaps do not.
            if (req_last[grant_id] || byte_cnt == BW'(MAX_MSG_LEN - 1)) begin
              last_grant <= grant_id;
              busy       <= 1'b0;
              state      <= IDLE;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: byte/grant scoreboard, a round-robin
// vector table, and directed credit, length-guard, bubble and reset sequences.
module tb_uart_tx_arbiter;

  localparam int NR = 3;
  localparam int BC = 10 * (1000 / 100) + 2;

  logic            clock = 1'b0;
  logic            reset_n = 1'b0;
  logic [NR-1:0]   req_valid = '0;
  logic [NR-1:0]   req_last = '0;
  logic [8*NR-1:0] req_data = '0;
  logic [NR-1:0]   req_ready;
  logic [7:0]      tx_fifo_data_in;
  logic            tx_fifo_write_en;
  logic [1:0]      grant_id;
  logic            busy;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;

  logic [8:0]    srcq [NR][$];
  logic [NR-1:0] hold = '0;
  logic [NR-1:0] hs = '0;
  logic [7:0]    exp_bytes[$];
  logic [1:0]    exp_grant[$];
  int            acc_times[$];
  logic          busy_prev = 1'b0;
  logic          prev_hs = 1'b0;

  typedef struct packed {
    logic [2:0] mask;
    logic [1:0] exp;
  } arb_vec_t;

  arb_vec_t tab [12];

  uart_tx_arbiter #(
    .NUM_REQ        (NR),
    .CLOCK_FREQUENCY(1000),
    .BAUD_RATE      (100),
    .FIFO_DEPTH     (4),
    .MAX_MSG_LEN    (8)
  ) dut (
    .clock           (clock),
    .reset_n         (reset_n),
    .req_valid       (req_valid),
    .req_data        (req_data),
    .req_last        (req_last),
    .req_ready       (req_ready),
    .tx_fifo_data_in (tx_fifo_data_in),
    .tx_fifo_write_en(tx_fifo_write_en),
    .grant_id        (grant_id),
    .busy            (busy)
  );

  always #5 clock = ~clock;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic restart_sources();
    for (int i = 0; i < NR; i++) srcq[i].delete();
    hs = '0;
  endtask

  task automatic src(input int id, input int seq, input bit last);
    srcq[id].push_back({last, 4'(id), 4'(seq)});
  endtask

  task automatic exp_byte(input int id, input int seq);
    exp_bytes.push_back({4'(id), 4'(seq)});
  endtask

  task automatic do_reset();
    tick();
    reset_n = 1'b0;
    restart_sources();
    hold = '0;
    repeat (2) tick();
    @(negedge clock);
    check("rst_ready", req_ready, 0);
    check("rst_write_en", tx_fifo_write_en, 0);
    check("rst_data", tx_fifo_data_in, 0);
    check("rst_busy", busy, 0);
    check("rst_grant", grant_id, 0);
    tick();
    reset_n = 1'b1;
    acc_times.delete();
  endtask

  task automatic wait_acc(input int n, input int budget, input string name);
    int k;
    k = 0;
    while (acc_times.size() < n && k < budget) begin
      tick();
      k++;
    end
    if (acc_times.size() < n) begin
      n_vec++;
      n_err++;
      $display("FAIL %s: %0d of %0d bytes accepted within %0d cycles",
               name, acc_times.size(), n, budget);
    end
  endtask

  // Cycle index since reset release: first clock edge with reset_n high is 1.
  initial forever begin
    @(posedge clock);
    cyc = reset_n ? cyc + 1 : 0;
  end

  // Requester model: presents the head of each source queue, pops on handshake.
  initial begin
    logic [8:0] f;
    forever begin
      @(posedge clock);
      #2;
      for (int i = 0; i < NR; i++) begin
        if (hs[i] && srcq[i].size() > 0) void'(srcq[i].pop_front());
        if (srcq[i].size() > 0 && !hold[i]) begin
          f                  = srcq[i][0];
          req_valid[i]       = 1'b1;
          req_last[i]        = f[8];
          req_data[8*i +: 8] = f[7:0];
        end else begin
          req_valid[i] = 1'b0;
          req_last[i]  = 1'b0;
        end
      end
    end
  end

  // Output monitor: write latency, byte order, grant order, ready exclusivity.
  initial begin
    logic [7:0]    eb;
    logic [1:0]    eg;
    logic [NR-1:0] oh;
    forever begin
      @(negedge clock);
      if (prev_hs || tx_fifo_write_en === 1'b1)
        check("write_latency", tx_fifo_write_en, prev_hs);
      if (tx_fifo_write_en === 1'b1) begin
        n_vec++;
        if (exp_bytes.size() == 0) begin
          n_err++;
          $display("FAIL tx_byte: got %02h, expected no write", tx_fifo_data_in);
        end else begin
          eb = exp_bytes.pop_front();
          if (tx_fifo_data_in !== eb) begin
            n_err++;
            $display("FAIL tx_byte: got %02h, expected %02h", tx_fifo_data_in, eb);
          end
        end
      end
      if (busy === 1'b1 && !busy_prev) begin
        n_vec++;
        if (exp_grant.size() == 0) begin
          n_err++;
          $display("FAIL grant: got %0d, expected no grant", grant_id);
        end else begin
          eg = exp_grant.pop_front();
          if (grant_id !== eg) begin
            n_err++;
            $display("FAIL grant: got %0d, expected %0d", grant_id, eg);
          end
        end
      end
      busy_prev = (busy === 1'b1);
      if (|req_ready) begin
        oh = '0;
        if (busy === 1'b1) oh[grant_id] = 1'b1;
        check("ready_onehot", req_ready, oh);
      end
      hs = reset_n ? (req_valid & req_ready) : '0;
      if (|hs) acc_times.push_back(cyc + 1);
      prev_hs = |hs;
    end
  end

  initial begin
    tab[0]  = '{3'b111, 2'd0};
    tab[1]  = '{3'b111, 2'd1};
    tab[2]  = '{3'b111, 2'd2};
    tab[3]  = '{3'b101, 2'd0};
    tab[4]  = '{3'b110, 2'd1};
    tab[5]  = '{3'b011, 2'd0};
    tab[6]  = '{3'b100, 2'd2};
    tab[7]  = '{3'b010, 2'd1};
    tab[8]  = '{3'b011, 2'd0};
    tab[9]  = '{3'b001, 2'd0};
    tab[10] = '{3'b110, 2'd1};
    tab[11] = '{3'b101, 2'd2};

    // Credits start empty: first accept after one byte time plus arbitration.
    do_reset();
    for (int s = 0; s < 4; s++) begin
      src(0, s, s == 3);
      exp_byte(0, s);
    end
    exp_grant.push_back(2'd0);
    wait_acc(4, 600, "t1_stream");
    if (acc_times.size() >= 4) begin
      check("t1_first_accept", acc_times[0], BC + 2);
      check("t1_gap_2_3", acc_times[2] - acc_times[1], BC);
      check("t1_gap_3_4", acc_times[3] - acc_times[2], BC);
    end

    // Saturated credits: 4-byte burst, then timer-paced bytes.
    repeat (600) tick();
    while (cyc % BC != 10) tick();
    acc_times.delete();
    for (int s = 0; s < 6; s++) begin
      src(0, s, s == 5);
      exp_byte(0, s);
    end
    exp_grant.push_back(2'd0);
    wait_acc(6, 400, "t2_burst");
    if (acc_times.size() >= 6) begin
      check("t2_gap_1_2", acc_times[1] - acc_times[0], 1);
      check("t2_gap_2_3", acc_times[2] - acc_times[1], 1);
      check("t2_gap_3_4", acc_times[3] - acc_times[2], 1);
      check("t2_byte5_after_wrap", acc_times[4] % BC, 1);
      check("t2_gap_5_6", acc_times[5] - acc_times[4], BC);
    end

    // Round-robin table, one-byte messages.
    do_reset();
    repeat (500) tick();
    for (int v = 0; v < 12; v++) begin
      restart_sources();
      for (int i = 0; i < NR; i++) if (tab[v].mask[i]) src(i, v, 1'b1);
      exp_grant.push_back(tab[v].exp);
      exp_byte(int'(tab[v].exp), v);
      wait_acc(v + 1, 300, "arb_vec");
    end
    restart_sources();

    // All three with two 2-byte messages queued.
    do_reset();
    for (int m = 0; m < 2; m++) begin
      for (int i = 0; i < NR; i++) begin
        src(i, 2 * m, 1'b0);
        src(i, 2 * m + 1, 1'b1);
        exp_grant.push_back(2'(i));
        exp_byte(i, 2 * m);
        exp_byte(i, 2 * m + 1);
      end
    end
    wait_acc(12, 2000, "t3_rr");

    // Length guard: req1 cut after 8 bytes, req2 served, req1 resumes.
    do_reset();
    for (int s = 0; s < 10; s++) src(1, s, s == 9);
    src(2, 0, 1'b0);
    src(2, 1, 1'b1);
    exp_grant.push_back(2'd1);
    for (int s = 0; s < 8; s++) exp_byte(1, s);
    exp_grant.push_back(2'd2);
    exp_byte(2, 0);
    exp_byte(2, 1);
    exp_grant.push_back(2'd1);
    exp_byte(1, 8);
    exp_byte(1, 9);
    wait_acc(12, 2000, "t4_guard");

    // Valid bubble on the granted requester holds the grant.
    do_reset();
    repeat (500) tick();
    for (int s = 0; s < 4; s++) begin
      src(0, s, s == 3);
      exp_byte(0, s);
    end
    src(2, 0, 1'b1);
    exp_grant.push_back(2'd0);
    exp_grant.push_back(2'd2);
    exp_byte(2, 0);
    wait_acc(1, 200, "t5_first");
    hold[0] = 1'b1;
    repeat (5) begin
      @(negedge clock);
      check("t5_ready2", req_ready[2], 0);
      check("t5_busy", busy, 1);
      check("t5_grant", grant_id, 0);
    end
    tick();
    hold[0] = 1'b0;
    check("t5_no_accept_in_bubble", acc_times.size(), 1);
    wait_acc(5, 600, "t5_rest");

    // Reset mid-stream aborts the message and empties the credits.
    do_reset();
    repeat (500) tick();
    for (int s = 0; s < 8; s++) begin
      src(0, s, s == 7);
      exp_byte(0, s);
    end
    exp_grant.push_back(2'd0);
    wait_acc(2, 200, "t6_partial");
    reset_n = 1'b0;
    restart_sources();
    while (exp_bytes.size() > 1) void'(exp_bytes.pop_back());
    @(negedge clock);
    @(negedge clock);
    check("t6_write_en", tx_fifo_write_en, 0);
    check("t6_ready", req_ready, 0);
    check("t6_busy", busy, 0);
    check("t6_data", tx_fifo_data_in, 0);
    tick();
    reset_n = 1'b1;
    acc_times.delete();
    src(0, 8, 1'b1);
    exp_byte(0, 8);
    exp_grant.push_back(2'd0);
    wait_acc(1, 300, "t6_restart");
    if (acc_times.size() >= 1) check("t6_first_accept", acc_times[0], BC + 2);

    repeat (5) tick();
    check("sb_bytes_left", exp_bytes.size(), 0);
    check("sb_grants_left", exp_grant.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
